// File: rtl/ins_cfg_parser.sv
// ins_cfg_parser
//   Hunts an AXI-stream-like FIFO for a double instruction header, captures
//   the three configuration words that follow, pulses start to the control
//   FSM and stays busy until op_done.
//
// Ports
//   clk               rising-edge clock
//   rstn              asynchronous active-low reset
//   fifo_data_din     head word of the input FIFO (TBITS)
//   fifo_strb_din     byte strobes of the head word (TBYTE)
//   fifo_last_din     TLAST of the head word
//   fifo_user_din     TUSER of the head word (unused)
//   fifo_empty_n_din  FIFO holds at least one word
//   fifo_read_dout    pop request (word consumed when this and empty_n are 1)
//   op_done           layer-complete indication from the control FSM
//   cfg0..cfg2        captured configuration words
//   cfg_valid         cfg0..cfg2 hold a complete, accepted instruction
//   start_pulse       one-cycle start to the control FSM
//   busy              instruction issued, op_done not yet seen
//   err               sticky protocol error (cleared by the next first header)
//   drop_cnt          words discarded while hunting, saturating at 255
//
// Build option
//   INS_STRB_CHECK_EN  when defined, words whose strobes are not all ones are
//                      never accepted as headers or configuration words.
module ins_cfg_parser #(
    parameter int               TBITS     = 64,
    parameter int               TBYTE     = 8,
    parameter logic [TBITS-1:0] INST_HEAD = 64'hefef123abbeeff22
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [TBITS-1:0] fifo_data_din,
    input  logic [TBYTE-1:0] fifo_strb_din,
    input  logic             fifo_last_din,
    input  logic             fifo_user_din,
    input  logic             fifo_empty_n_din,
    output logic             fifo_read_dout,
    input  logic             op_done,
    output logic [TBITS-1:0] cfg0,
    output logic [TBITS-1:0] cfg1,
    output logic [TBITS-1:0] cfg2,
    output logic             cfg_valid,
    output logic             start_pulse,
    output logic             busy,
    output logic             err,
    output logic [7:0]       drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAD2 = 3'd1,
        S_CFG   = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t           r_state, w_state_next;
    logic [1:0]       r_idx, w_idx_next;
    logic [TBITS-1:0] r_cfg [3];
    logic [2:0]       w_cfg_we;
    logic             r_cfg_valid, w_cfg_valid_next;
    logic             r_err, w_err_next;
    logic [7:0]       r_drop_cnt, w_drop_cnt_next;

    logic w_pop;
    logic w_is_head;
    logic w_strb_ok;
    logic w_unused;

    // Reads are requested only in the states that consume words; START and
    // RUN leave the FIFO untouched so the next instruction waits there.
    assign w_pop = fifo_empty_n_din &&
                   ((r_state == S_IDLE) || (r_state == S_HEAD2) || (r_state == S_CFG));
    assign fifo_read_dout = w_pop;

    assign w_is_head = (fifo_data_din == INST_HEAD);

`ifdef INS_STRB_CHECK_EN
    assign w_strb_ok = &fifo_strb_din;
    assign w_unused  = fifo_user_din;
`else
    assign w_strb_ok = 1'b1;
    assign w_unused  = ^{fifo_user_din, fifo_strb_din};
`endif

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_cfg_we         = 3'b000;
        w_cfg_valid_next = r_cfg_valid;
        w_err_next       = r_err;
        w_drop_cnt_next  = r_drop_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    if (w_is_head && w_strb_ok) begin
                        w_state_next = S_HEAD2;
                        w_err_next   = 1'b0;
                    end else if (r_drop_cnt != 8'hff) begin
                        w_drop_cnt_next = r_drop_cnt + 8'd1;
                    end
                end
            end
            S_HEAD2: begin
                if (w_pop) begin
                    if (w_is_head && w_strb_ok) begin
                        w_state_next = S_CFG;
                        w_idx_next   = 2'd0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_err_next   = 1'b1;
                    end
                end
            end
            S_CFG: begin
                if (w_pop) begin
                    if (!w_strb_ok) begin
                        w_state_next = S_IDLE;
                        w_err_next   = 1'b1;
                    end else begin
                        // The word is stored even when this edge aborts on
                        // TLAST; cfg_valid alone tells whether it is usable.
                        w_cfg_we = 3'b001 << r_idx;
                        if (r_idx == 2'd2) begin
                            if (fifo_last_din) begin
                                w_state_next     = S_START;
                                w_cfg_valid_next = 1'b1;
                            end else begin
                                w_state_next = S_IDLE;
                                w_err_next   = 1'b1;
                            end
                        end else if (fifo_last_din) begin
                            w_state_next = S_IDLE;
                            w_err_next   = 1'b1;
                        end else begin
                            w_idx_next = r_idx + 2'd1;
                        end
                    end
                end
            end
            S_START: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (op_done) begin
                    w_state_next     = S_IDLE;
                    w_cfg_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next     = S_IDLE;
                w_cfg_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_cfg_valid <= 1'b0;
            r_err       <= 1'b0;
            r_drop_cnt  <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                r_cfg[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_cfg_valid <= w_cfg_valid_next;
            r_err       <= w_err_next;
            r_drop_cnt  <= w_drop_cnt_next;
            for (int i = 0; i < 3; i++) begin
                if (w_cfg_we[i]) begin
                    r_cfg[i] <= fifo_data_din;
                end
            end
        end
    end

    assign cfg0        = r_cfg[0];
    assign cfg1        = r_cfg[1];
    assign cfg2        = r_cfg[2];
    assign cfg_valid   = r_cfg_valid;
    assign start_pulse = (r_state == S_START);
    assign busy        = (r_state == S_START) || (r_state == S_RUN);
    assign err         = r_err;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_ins_cfg_parser.sv
// Testbench for ins_cfg_parser: a FIFO model feeds word streams, a reference
// scanner predicts accepted instructions, error flag, drop count and cfg
// contents; a monitor checks every start pulse against the expected queue.
module tb_ins_cfg_parser;

    localparam logic [63:0] HEAD = 64'hefef123abbeeff22;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } word_t;

    typedef struct {
        logic [63:0] c0;
        logic [63:0] c1;
        logic [63:0] c2;
    } trip_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] fifo_data_din;
    logic [7:0]  fifo_strb_din;
    logic        fifo_last_din;
    logic        fifo_user_din;
    logic        fifo_empty_n_din;
    logic        fifo_read_dout;
    logic        op_done;
    logic [63:0] cfg0, cfg1, cfg2;
    logic        cfg_valid, start_pulse, busy, err;
    logic [7:0]  drop_cnt;

    ins_cfg_parser dut (
        .clk(clk), .rstn(rstn),
        .fifo_data_din(fifo_data_din), .fifo_strb_din(fifo_strb_din),
        .fifo_last_din(fifo_last_din), .fifo_user_din(fifo_user_din),
        .fifo_empty_n_din(fifo_empty_n_din), .fifo_read_dout(fifo_read_dout),
        .op_done(op_done),
        .cfg0(cfg0), .cfg1(cfg1), .cfg2(cfg2),
        .cfg_valid(cfg_valid), .start_pulse(start_pulse), .busy(busy),
        .err(err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    word_t       fq[$];      // FIFO contents presented to the DUT
    word_t       sbuf[$];    // stream being assembled
    trip_t       exp_q[$];   // scoreboard of expected instructions
    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          gate_mode = 0;
    bit          hold_run = 1'b0;
    int          m_drop = 0;
    bit          m_err = 1'b0;
    logic [63:0] m_cfg [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        if (v == HEAD) v = ~v;
        return v;
    endfunction

    function automatic bit strb_ok(input logic [7:0] s);
`ifdef INS_STRB_CHECK_EN
        return s == 8'hff;
`else
        return 1'b1;
`endif
    endfunction

    task automatic add(input logic [63:0] d, input logic [7:0] s, input logic l);
        word_t w;
        w.data = d; w.strb = s; w.last = l;
        sbuf.push_back(w);
    endtask

    task automatic add_instr(input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic [7:0] s1);
        add(HEAD, 8'hff, 1'($urandom_range(0, 1)));
        add(HEAD, 8'hff, 1'($urandom_range(0, 1)));
        add(a, 8'hff, 1'b0);
        add(b, s1, 1'b0);
        add(c, 8'hff, 1'b1);
    endtask

    // Reference scan: walk the stream word by word looking for two headers
    // followed by exactly three payload words, the third carrying TLAST.
    task automatic model_stream();
        int    p;
        int    n;
        word_t w;
        trip_t t;
        p = 0;
        n = sbuf.size();
        while (p < n) begin
            w = sbuf[p]; p++;
            if (!(w.data == HEAD && strb_ok(w.strb))) begin
                if (m_drop < 255) m_drop++;
                continue;
            end
            m_err = 1'b0;
            if (p >= n) break;
            w = sbuf[p]; p++;
            if (!(w.data == HEAD && strb_ok(w.strb))) begin
                m_err = 1'b1;
                continue;
            end
            for (int k = 0; k < 3; k++) begin
                if (p >= n) break;
                w = sbuf[p]; p++;
                if (!strb_ok(w.strb)) begin m_err = 1'b1; break; end
                m_cfg[k] = w.data;
                if (k < 2 && w.last) begin m_err = 1'b1; break; end
                if (k == 2) begin
                    if (w.last) begin
                        t.c0 = m_cfg[0]; t.c1 = m_cfg[1]; t.c2 = m_cfg[2];
                        exp_q.push_back(t);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic finish_stream(input string nm);
        int c;
        c = 0;
        while ((fq.size() != 0 || busy || exp_q.size() != 0) && c < 1500) begin
            @(negedge clk); #2;
            c++;
        end
        chk({nm, "_drain_timeout"}, 64'(c >= 1500), 64'd0);
        if (c >= 1500) exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        chk({nm, "_err"}, 64'(err), 64'(m_err));
        chk({nm, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
        chk({nm, "_cfg0"}, cfg0, m_cfg[0]);
        chk({nm, "_cfg1"}, cfg1, m_cfg[1]);
        chk({nm, "_cfg2"}, cfg2, m_cfg[2]);
        chk({nm, "_cfg_valid_idle"}, 64'(cfg_valid), 64'd0);
    endtask

    task automatic send_stream(input string nm);
        int nw;
        nw = sbuf.size();
        model_stream();
        foreach (sbuf[i]) fq.push_back(sbuf[i]);
        sbuf.delete();
        finish_stream(nm);
        $display("stream %s: %0d words, err=%0b drop_cnt=%0d", nm, nw, err, drop_cnt);
    endtask

    task automatic reset_check(input string nm);
        rstn = 1'b0;
        fq.delete();
        exp_q.delete();
        m_drop = 0; m_err = 1'b0;
        for (int i = 0; i < 3; i++) m_cfg[i] = 64'd0;
        #1;
        chk({nm, "_cfg0"}, cfg0, 64'd0);
        chk({nm, "_cfg1"}, cfg1, 64'd0);
        chk({nm, "_cfg2"}, cfg2, 64'd0);
        chk({nm, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
        chk({nm, "_err"}, 64'(err), 64'd0);
        chk({nm, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_start"}, 64'(start_pulse), 64'd0);
        chk({nm, "_read"}, 64'(fifo_read_dout), 64'(fifo_empty_n_din));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        $display("reset %s applied", nm);
    endtask

    // FIFO model: present the head word at the falling edge, consume it at
    // the rising edge if the DUT requested it.
    initial begin
        bit tgl;
        bit g;
        bit will_pop;
        tgl = 1'b0;
        forever begin
            @(negedge clk);
            tgl = ~tgl;
            case (gate_mode)
                0:       g = 1'b1;
                1:       g = tgl;
                default: g = 1'($urandom_range(0, 1));
            endcase
            fifo_user_din = 1'($urandom_range(0, 1));
            if (fq.size() > 0 && g) begin
                fifo_data_din    = fq[0].data;
                fifo_strb_din    = fq[0].strb;
                fifo_last_din    = fq[0].last;
                fifo_empty_n_din = 1'b1;
            end else begin
                fifo_data_din    = rnd64();
                fifo_strb_din    = 8'($urandom);
                fifo_last_din    = 1'($urandom_range(0, 1));
                fifo_empty_n_din = 1'b0;
            end
            #1;
            will_pop = fifo_read_dout && fifo_empty_n_din && rstn;
            @(posedge clk);
            if (will_pop && rstn && fq.size() > 0) begin
                fq.delete(0);
                n_pop++;
            end
        end
    end

    // Control FSM stand-in: acknowledge each start after 1..4 cycles; also
    // throw stray op_done pulses while not busy, which must be ignored.
    initial begin
        forever begin
            @(negedge clk);
            op_done = 1'b0;
            if (start_pulse && !hold_run) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                op_done = 1'b1;
            end else if (!busy && $urandom_range(0, 7) == 0) begin
                op_done = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit    prev_start;
        bit    od_seen;
        trip_t t;
        prev_start = 1'b0;
        od_seen    = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!rstn) begin
                prev_start = 1'b0;
                od_seen    = 1'b0;
                continue;
            end
            if (od_seen) begin
                chk("busy_after_op_done", 64'(busy), 64'd0);
                chk("cfg_valid_after_op_done", 64'(cfg_valid), 64'd0);
            end
            if (start_pulse) begin
                chk("start_single_cycle", 64'(prev_start), 64'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: got start_pulse=1, expected no instruction pending");
                end else begin
                    t = exp_q.pop_front();
                    chk("start_cfg0", cfg0, t.c0);
                    chk("start_cfg1", cfg1, t.c1);
                    chk("start_cfg2", cfg2, t.c2);
                    chk("start_cfg_valid", 64'(cfg_valid), 64'd1);
                    chk("start_busy", 64'(busy), 64'd1);
                    $display("instruction accepted: %h %h %h", t.c0, t.c1, t.c2);
                end
            end
            if (fifo_empty_n_din) begin
                chk("read_gating", 64'(fifo_read_dout), 64'(!busy));
            end
            od_seen    = op_done && busy && !start_pulse;
            prev_start = start_pulse;
        end
    end

    initial begin
        int          base;
        int          c;
        logic [63:0] a;
        string       nm;
        rstn             = 1'b0;
        op_done          = 1'b0;
        fifo_data_din    = 64'd0;
        fifo_strb_din    = 8'd0;
        fifo_last_din    = 1'b0;
        fifo_user_din    = 1'b0;
        fifo_empty_n_din = 1'b0;
        for (int i = 0; i < 3; i++) m_cfg[i] = 64'd0;

        #13;
        chk("por_cfg0", cfg0, 64'd0);
        chk("por_cfg_valid", 64'(cfg_valid), 64'd0);
        chk("por_err", 64'(err), 64'd0);
        chk("por_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_start", 64'(start_pulse), 64'd0);
        chk("por_read", 64'(fifo_read_dout), 64'(fifo_empty_n_din));
        @(negedge clk);
        rstn = 1'b1;

        // Basic instruction
        gate_mode = 0;
        add_instr(64'hffff000000000000, 64'heeeeeeeeeeeeeeee, 64'heeeeeeeeeeeeeeee, 8'hff);
        send_stream("basic");

        // Junk before a header, then saturation of the drop counter
        for (int i = 0; i < 3; i++) add(rnd64(), 8'hff, 1'($urandom_range(0, 1)));
        add_instr(rnd64(), rnd64(), rnd64(), 8'hff);
        send_stream("junk3");
        for (int i = 0; i < 300; i++) add(rnd64(), 8'($urandom), 1'($urandom_range(0, 1)));
        send_stream("junk300");

        // Bad second header, then recovery
        add(HEAD, 8'hff, 1'b0);
        add(64'd0, 8'hff, 1'b0);
        send_stream("bad_head2");
        add_instr(rnd64(), rnd64(), rnd64(), 8'hff);
        send_stream("recover");

        // Early TLAST on the second cfg word, missing TLAST on the third
        add(HEAD, 8'hff, 1'b0); add(HEAD, 8'hff, 1'b0);
        add(rnd64(), 8'hff, 1'b0); add(rnd64(), 8'hff, 1'b1);
        send_stream("early_last");
        add(HEAD, 8'hff, 1'b0); add(HEAD, 8'hff, 1'b0);
        add(rnd64(), 8'hff, 1'b0); add(rnd64(), 8'hff, 1'b0); add(rnd64(), 8'hff, 1'b0);
        send_stream("late_last");
        reset_check("rst_idle");

        // Stalling FIFO, with words waiting behind the instruction
        gate_mode = 1;
        add_instr(rnd64(), rnd64(), rnd64(), 8'hff);
        for (int i = 0; i < 4; i++) add(rnd64(), 8'hff, 1'b0);
        send_stream("stall");

        // Partial strobes on cfg1
        gate_mode = 0;
        add_instr(rnd64(), rnd64(), rnd64(), 8'h0f);
        send_stream("strb_cfg1");

        // Reset in the middle of CFG
        base = n_pop;
        a = rnd64();
        add(rnd64(), 8'hff, 1'b0);
        add(HEAD, 8'hff, 1'b0); add(HEAD, 8'hff, 1'b0);
        add(a, 8'hff, 1'b0); add(rnd64(), 8'hff, 1'b0); add(rnd64(), 8'hff, 1'b1);
        foreach (sbuf[i]) fq.push_back(sbuf[i]);
        sbuf.delete();
        c = 0;
        while (n_pop < base + 4 && c < 100) begin
            @(posedge clk); #2;
            c++;
        end
        chk("midcfg_reached", 64'(c >= 100), 64'd0);
        chk("midcfg_cfg0", cfg0, a);
        reset_check("rst_cfg");

        // Reset in the middle of RUN, with words waiting in the FIFO
        hold_run = 1'b1;
        add_instr(rnd64(), rnd64(), rnd64(), 8'hff);
        model_stream();
        foreach (sbuf[i]) fq.push_back(sbuf[i]);
        sbuf.delete();
        c = 0;
        while (!busy && c < 200) begin
            @(negedge clk); #2;
            c++;
        end
        chk("run_reached", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            word_t w;
            w.data = rnd64(); w.strb = 8'hff; w.last = 1'b0;
            fq.push_back(w);
        end
        repeat (6) @(negedge clk);
        #2;
        chk("run_no_reads", 64'(fq.size()), 64'd5);
        chk("run_cfg_valid", 64'(cfg_valid), 64'd1);
        @(posedge clk); #2;
        reset_check("rst_run");
        hold_run = 1'b0;

        // Random streams built from complete segments
        gate_mode = 2;
        for (int s = 0; s < 30; s++) begin
            int nseg;
            nseg = $urandom_range(1, 5);
            for (int g = 0; g < nseg; g++) begin
                case ($urandom_range(0, 5))
                    0: begin
                        int nj;
                        nj = $urandom_range(1, 3);
                        for (int i = 0; i < nj; i++) add(rnd64(), 8'($urandom), 1'($urandom_range(0, 1)));
                    end
                    1: add_instr(rnd64(), rnd64(), rnd64(), 8'hff);
                    2: begin
                        add(HEAD, 8'hff, 1'($urandom_range(0, 1)));
                        add(rnd64(), 8'hff, 1'($urandom_range(0, 1)));
                    end
                    3: begin
                        int k;
                        k = $urandom_range(0, 1);
                        add(HEAD, 8'hff, 1'b0); add(HEAD, 8'hff, 1'b0);
                        for (int i = 0; i <= k; i++) add(rnd64(), 8'hff, 1'(i == k));
                    end
                    4: begin
                        add(HEAD, 8'hff, 1'b0); add(HEAD, 8'hff, 1'b0);
                        for (int i = 0; i < 3; i++) add(rnd64(), 8'hff, 1'b0);
                    end
                    default: begin
                        int k;
                        k = $urandom_range(0, 2);
                        add(HEAD, 8'hff, 1'b0); add(HEAD, 8'hff, 1'b0);
                        for (int i = 0; i < 3; i++)
                            add(rnd64(), (i == k) ? 8'($urandom) : 8'hff, 1'(i == 2));
                    end
                endcase
            end
            nm = $sformatf("rand%0d", s);
            send_stream(nm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ins_cfg_parser.md
INS_CFG_PARSER -- requirements
Module: ins_cfg_parser

Interface
REQ-001 Parameter TBITS, 64, FIFO data width in bits.
REQ-002 Parameter TBYTE, 8, FIFO strobe width (TBITS/8).
REQ-003 Parameter INST_HEAD, 64'hefef123abbeeff22, instruction header word.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 fifo_data_din  in  TBITS  head word of the input-stream FIFO.
REQ-007 fifo_strb_din  in  TBYTE  byte strobes of the head word.
REQ-008 fifo_last_din  in  1  TLAST of the head word.
REQ-009 fifo_user_din  in  1  TUSER of the head word; ignored.
REQ-010 fifo_empty_n_din  in  1  FIFO holds at least one word.
REQ-011 fifo_read_dout  out  1  pop request; a word is consumed at an edge where fifo_read_dout and fifo_empty_n_din are both 1.
REQ-012 op_done  in  1  layer-complete indication from the control FSM.
REQ-013 cfg0, cfg1, cfg2  out  TBITS each  captured configuration words.
REQ-014 cfg_valid  out  1  cfg0..cfg2 hold a complete, accepted instruction.
REQ-015 start_pulse  out  1  one-cycle start to the control FSM.
REQ-016 busy  out  1  instruction issued, op_done not yet seen.
REQ-017 err  out  1  sticky protocol error.
REQ-018 drop_cnt  out  8  count of words discarded while hunting for a header; saturates at 255.

Function
REQ-019 States: IDLE, HEAD2, CFG, START, RUN; state held in a register.
REQ-020 fifo_read_dout = fifo_empty_n_din AND state in {IDLE, HEAD2, CFG}; combinational, no other term.
REQ-021 IDLE: consumed word == INST_HEAD -> HEAD2, and err cleared; any other consumed word is dropped, drop_cnt +1 (holds at 255), state stays IDLE.
REQ-022 HEAD2: consumed word == INST_HEAD -> CFG, cfg index cleared to 0; any other word -> IDLE, err set.
REQ-023 CFG: consumed word written to cfg[index] at that edge; index increments 0->1->2.
REQ-024 CFG, index 2 with fifo_last_din=1 -> START; index 2 with fifo_last_din=0 -> IDLE, err set.
REQ-025 CFG, index 0 or 1 with fifo_last_din=1 (early last) -> IDLE, err set; cfg_valid stays 0.
REQ-026 fifo_last_din is ignored in IDLE and HEAD2.
REQ-027 START lasts exactly one cycle, then RUN. start_pulse = (state == START): it is high in the cycle after the edge that consumed cfg2.
REQ-028 cfg_valid is set on entry to START, stays set through RUN, and clears on the RUN->IDLE edge.
REQ-029 cfg_valid is 0 whenever state is IDLE, HEAD2 or CFG.
REQ-030 busy = (state == START or RUN).
REQ-031 RUN: op_done=1 -> IDLE at that edge; no FIFO reads occur in START or RUN.
REQ-032 op_done is ignored in IDLE, HEAD2, CFG and START.
REQ-033 While fifo_empty_n_din=0, state, index and cfg registers hold; waiting has no timeout.
REQ-034 cfg registers change only on CFG-state consumes.
REQ-035 cfg registers are not cleared by an error; a partial write followed by an abort leaves cfg_valid=0.

Reset
REQ-036 rstn=0 forces immediately, regardless of clk: state=IDLE, index=0, cfg0..cfg2=0, cfg_valid=0, err=0, drop_cnt=0.
REQ-037 Consequence of REQ-036 and REQ-020/027/030: start_pulse=0, busy=0, and fifo_read_dout = fifo_empty_n_din.
REQ-038 Reset during CFG or RUN abandons the instruction; after release, the block hunts for a fresh header.

Configuration
REQ-039 Macro INS_STRB_CHECK_EN.
REQ-040 With INS_STRB_CHECK_EN defined: a word consumed in HEAD2 or CFG with fifo_strb_din != all-ones -> IDLE, err set, word not stored.
REQ-041 With INS_STRB_CHECK_EN defined: in IDLE, a word with fifo_strb_din != all-ones is dropped even if it matches INST_HEAD.
REQ-042 Without INS_STRB_CHECK_EN: fifo_strb_din is ignored entirely.

Verification
REQ-043 Stream INST_HEAD, INST_HEAD, 64'hffff000000000000, 64'heeeeeeeeeeeeeeee, 64'heeeeeeeeeeeeeeee (last=1) -> cfg0/1/2 equal those values, one start_pulse, cfg_valid=1, busy=1; op_done two cycles later -> IDLE, cfg_valid=0, busy=0.
REQ-044 Three junk words, then a valid instruction -> drop_cnt=3, instruction accepted; 300 junk words -> drop_cnt=255.
REQ-045 INST_HEAD, 64'h0 -> err=1, state IDLE; a following valid instruction clears err and issues start_pulse.
REQ-046 Valid headers, then last=1 on the 2nd cfg word -> err=1, no start_pulse, cfg_valid=0; last=0 on the 3rd cfg word -> err=1.
REQ-047 fifo_empty_n_din toggled 0/1 every cycle during a valid instruction -> same cfg values, start_pulse exactly once; FIFO words present during RUN are not read until op_done.
REQ-048 rstn pulsed low mid-CFG, and a separate test with rstn pulsed low mid-RUN -> all outputs return to reset values asynchronously; with INS_STRB_CHECK_EN, strb=8'h0f on cfg1 -> err=1, no start.
